hazard_stall_ctrl: RTL and testbench

//  Stall/flush controller for the 5-stage MIPS pipeline: handles the hazards the forwarding unit cannot.

---
 rtl/hazard_stall_ctrl.sv | 125 ++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Purpose : pipeline stall/flush controller for load-use, multi-cycle multiply and taken-branch hazards.
// Latency : enables and flushes are combinational (same cycle); state and event counters update on clk_i.
// Backpres: stalls PC/IF_ID on load-use, freezes PC/IF_ID/ID_EX while a multiply occupies EX.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   IF_ID_rs/rt/uses_rt          source registers of the instruction in ID
//   ID_EX_memread, ID_EX_rt      load in EX and its destination register
//   mul_issue_i                  multiply leaving ID into EX this cycle
//   branch_taken_i               branch in MEM resolved taken
//   pc_write_o, IF_ID_write_o, ID_EX_write_o      stage write enables
//   IF_ID_flush_o, ID_EX_flush_o, EX_MEM_flush_o  stage bubble inserts
//   stall_cnt_o, flush_cnt_o     saturating event counters
module hazard_stall_ctrl #(
   parameter int MUL_LAT = 3,
   parameter int CNT_W   = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [4:0]       IF_ID_rs,
   input  logic [4:0]       IF_ID_rt,
   input  logic             IF_ID_uses_rt,
   input  logic             ID_EX_memread,
   input  logic [4:0]       ID_EX_rt,
   input  logic             mul_issue_i,
   input  logic             branch_taken_i,
   output logic             pc_write_o,
   output logic             IF_ID_write_o,
   output logic             ID_EX_write_o,
   output logic             IF_ID_flush_o,
   output logic             ID_EX_flush_o,
   output logic             EX_MEM_flush_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   // Width holding MUL_LAT-1 (at least one bit so MUL_LAT=1 still elaborates).
   localparam int MCW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
   localparam logic [MCW-1:0] MUL_INIT = MCW'(MUL_LAT - 1);

   typedef enum logic [0:0] {RUN, MUL_BUSY} state_t;

   state_t           state_q, state_d;
   logic [MCW-1:0]   mul_cnt_q, mul_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             load_use;
   logic             stall_inc;
   logic             flush_inc;

   // r0 is never a real dependency; rt only matters when ID actually reads it.
   assign load_use = ID_EX_memread && (ID_EX_rt != 5'd0) &&
                     ((ID_EX_rt == IF_ID_rs) || (IF_ID_uses_rt && (ID_EX_rt == IF_ID_rt)));

   always_comb begin
      state_d        = state_q;
      mul_cnt_d      = mul_cnt_q;
      pc_write_o     = 1'b1;
      IF_ID_write_o  = 1'b1;
      ID_EX_write_o  = 1'b1;
      IF_ID_flush_o  = 1'b0;
      ID_EX_flush_o  = 1'b0;
      EX_MEM_flush_o = 1'b0;
      stall_inc      = 1'b0;
      flush_inc      = 1'b0;

      if (rst_i) begin
         pc_write_o     = 1'b0;
         IF_ID_write_o  = 1'b0;
         ID_EX_write_o  = 1'b0;
         IF_ID_flush_o  = 1'b1;
         ID_EX_flush_o  = 1'b1;
         EX_MEM_flush_o = 1'b1;
      end else if (branch_taken_i) begin
         // Squash everything younger than MEM, including a multiply still in EX.
         IF_ID_flush_o  = 1'b1;
         ID_EX_flush_o  = 1'b1;
         EX_MEM_flush_o = 1'b1;
         state_d        = RUN;
         mul_cnt_d      = '0;
         flush_inc      = 1'b1;
      end else if (state_q == MUL_BUSY) begin
         // Hold the multiply in EX and feed bubbles downstream until it completes.
         pc_write_o     = 1'b0;
         IF_ID_write_o  = 1'b0;
         ID_EX_write_o  = 1'b0;
         EX_MEM_flush_o = 1'b1;
         stall_inc      = 1'b1;
         mul_cnt_d      = mul_cnt_q - 1'b1;
         if (mul_cnt_q == MCW'(1)) begin
            state_d = RUN;
         end
      end else if (load_use) begin
         // mul_issue_i is deliberately ignored here; the held instruction re-presents it next cycle.
         pc_write_o    = 1'b0;
         IF_ID_write_o = 1'b0;
         ID_EX_flush_o = 1'b1;
         stall_inc     = 1'b1;
      end else if (mul_issue_i && (MUL_LAT > 1)) begin
         state_d   = MUL_BUSY;
         mul_cnt_d = MUL_INIT;
      end

      stall_cnt_d = (stall_inc && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
      flush_cnt_d = (flush_inc && (flush_cnt_q != '1)) ? flush_cnt_q + 1'b1 : flush_cnt_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= RUN;
         mul_cnt_q   <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         mul_cnt_q   <= mul_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

   logic       clk;
   logic       rst;
   logic [4:0] if_id_rs, if_id_rt, id_ex_rt;
   logic       if_id_uses_rt, id_ex_memread, mul_issue, branch_taken;

   logic        pc_w, ifid_w, idex_w, ifid_f, idex_f, exmem_f;
   logic [15:0] stall_cnt, flush_cnt;
   logic        s_pc_w, s_ifid_w, s_idex_w, s_ifid_f, s_idex_f, s_exmem_f;
   logic [3:0]  s_stall_cnt, s_flush_cnt;
   logic [5:0]  outs;

   int n_cmp = 0;
   int n_err = 0;

   // Main instance: default MUL_LAT=3, CNT_W=16.
   hazard_stall_ctrl #(.MUL_LAT(3), .CNT_W(16)) dut (
      .clk_i(clk), .rst_i(rst),
      .IF_ID_rs(if_id_rs), .IF_ID_rt(if_id_rt), .IF_ID_uses_rt(if_id_uses_rt),
      .ID_EX_memread(id_ex_memread), .ID_EX_rt(id_ex_rt),
      .mul_issue_i(mul_issue), .branch_taken_i(branch_taken),
      .pc_write_o(pc_w), .IF_ID_write_o(ifid_w), .ID_EX_write_o(idex_w),
      .IF_ID_flush_o(ifid_f), .ID_EX_flush_o(idex_f), .EX_MEM_flush_o(exmem_f),
      .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
   );

   // Narrow-counter instance sharing the same stimulus, used for saturation.
   hazard_stall_ctrl #(.MUL_LAT(3), .CNT_W(4)) dut_sat (
      .clk_i(clk), .rst_i(rst),
      .IF_ID_rs(if_id_rs), .IF_ID_rt(if_id_rt), .IF_ID_uses_rt(if_id_uses_rt),
      .ID_EX_memread(id_ex_memread), .ID_EX_rt(id_ex_rt),
      .mul_issue_i(mul_issue), .branch_taken_i(branch_taken),
      .pc_write_o(s_pc_w), .IF_ID_write_o(s_ifid_w), .ID_EX_write_o(s_idex_w),
      .IF_ID_flush_o(s_ifid_f), .ID_EX_flush_o(s_idex_f), .EX_MEM_flush_o(s_exmem_f),
      .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt)
   );

   // {pc_write, IF_ID_write, ID_EX_write, IF_ID_flush, ID_EX_flush, EX_MEM_flush}
   assign outs = {pc_w, ifid_w, idex_w, ifid_f, idex_f, exmem_f};

   localparam logic [5:0] O_RST   = 6'b000_111;
   localparam logic [5:0] O_RUN   = 6'b111_000;
   localparam logic [5:0] O_LDUSE = 6'b001_010;
   localparam logic [5:0] O_MUL   = 6'b000_001;
   localparam logic [5:0] O_BR    = 6'b111_111;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      if_id_rs = 5'd0; if_id_rt = 5'd0; if_id_uses_rt = 1'b0;
      id_ex_memread = 1'b0; id_ex_rt = 5'd0;
      mul_issue = 1'b0; branch_taken = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
   endtask

   initial begin
      idle();
      rst = 1'b1;

      // 1. reset
      tick(); tick();
      chk("rst_outs", 32'(outs), 32'(O_RST));
      chk("rst_stall", 32'(stall_cnt), 0);
      chk("rst_flush", 32'(flush_cnt), 0);
      rst = 1'b0;
      #1;
      chk("run_outs", 32'(outs), 32'(O_RUN));

      // 2. load-use on rs
      id_ex_memread = 1'b1; id_ex_rt = 5'd5; if_id_rs = 5'd5;
      #1;
      chk("ldu_rs_outs", 32'(outs), 32'(O_LDUSE));
      tick();
      chk("ldu_rs_cnt", 32'(stall_cnt), 1);
      idle();
      #1;
      chk("ldu_clear_outs", 32'(outs), 32'(O_RUN));
      // destination r0 never stalls
      id_ex_memread = 1'b1; id_ex_rt = 5'd0; if_id_rs = 5'd0;
      #1;
      chk("ldu_r0_outs", 32'(outs), 32'(O_RUN));
      // rt match but rt not used
      id_ex_rt = 5'd7; if_id_rt = 5'd7; if_id_rs = 5'd3; if_id_uses_rt = 1'b0;
      #1;
      chk("ldu_rt_unused", 32'(outs), 32'(O_RUN));
      if_id_uses_rt = 1'b1;
      #1;
      chk("ldu_rt_used", 32'(outs), 32'(O_LDUSE));
      tick();
      chk("ldu_rt_cnt", 32'(stall_cnt), 2);
      idle();

      // 3. multiply: issue cycle normal, then two held cycles
      mul_issue = 1'b1;
      #1;
      chk("mul_issue_outs", 32'(outs), 32'(O_RUN));
      tick();
      mul_issue = 1'b0;
      #1;
      chk("mul_busy1_outs", 32'(outs), 32'(O_MUL));
      tick();
      // load-use and a new mul must be ignored while busy
      id_ex_memread = 1'b1; id_ex_rt = 5'd9; if_id_rs = 5'd9; mul_issue = 1'b1;
      #1;
      chk("mul_busy2_outs", 32'(outs), 32'(O_MUL));
      chk("mul_busy2_cnt", 32'(stall_cnt), 3);
      tick();
      idle();
      #1;
      chk("mul_done_outs", 32'(outs), 32'(O_RUN));
      chk("mul_done_cnt", 32'(stall_cnt), 4);

      // 4. branch in first MUL_BUSY cycle
      do_reset();
      mul_issue = 1'b1;
      tick();
      mul_issue = 1'b0; branch_taken = 1'b1;
      #1;
      chk("br_mul_outs", 32'(outs), 32'(O_BR));
      tick();
      branch_taken = 1'b0;
      #1;
      chk("br_mul_after", 32'(outs), 32'(O_RUN));
      chk("br_mul_flush", 32'(flush_cnt), 1);
      chk("br_mul_stall", 32'(stall_cnt), 0);
      tick();
      chk("br_mul_stay_run", 32'(outs), 32'(O_RUN));

      // 5. branch beats load-use
      branch_taken = 1'b1; id_ex_memread = 1'b1; id_ex_rt = 5'd4; if_id_rs = 5'd4;
      #1;
      chk("br_ldu_outs", 32'(outs), 32'(O_BR));
      tick();
      idle();
      #1;
      chk("br_ldu_stall", 32'(stall_cnt), 0);
      chk("br_ldu_flush", 32'(flush_cnt), 2);

      // 6. saturation of the 4-bit counter over 20 stalls, then reset
      do_reset();
      id_ex_memread = 1'b1; id_ex_rt = 5'd12; if_id_rs = 5'd12;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (i == 14) chk("sat_at15", 32'(s_stall_cnt), 15);
      end
      chk("sat_hold", 32'(s_stall_cnt), 15);
      chk("sat_wide", 32'(stall_cnt), 20);
      chk("sat_outs", 32'({s_pc_w, s_ifid_w, s_idex_w, s_ifid_f, s_idex_f, s_exmem_f}), 32'(O_LDUSE));
      rst = 1'b1;
      tick();
      chk("sat_rst", 32'(s_stall_cnt), 0);
      chk("sat_rst_outs", 32'(outs), 32'(O_RST));
      rst = 1'b0;
      idle();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
